vx_pe_dispatch: RTL and testbench
=================================

VX_PE_DISPATCH -- requirements
Module: VX_pe_dispatch

Interface
REQ-001 SHALL have parameter PE_COUNT, default 2, number of processing elements (>=1).
REQ-002 SHALL have parameter REQ_DATAW, default 64, request payload width.
REQ-003 SHALL have parameter RSP_DATAW, default 64, response payload width.
REQ-004 SHALL have parameter MAX_PENDING, default 4, per-PE outstanding-request limit (>=1).
REQ-005 SHALL have parameter SEL_MODE, default 0: 0 = explicit select, 1 = least-loaded auto-select.
REQ-006 SHALL have ports: clk in 1 clock; reset_n in 1 synchronous active-low reset.
REQ-007 SHALL have ports: req_valid in 1; req_ready out 1; req_data in REQ_DATAW; req_sel in UP(CLOG2(PE_COUNT)) target PE.
REQ-008 SHALL have ports: pe_req_valid out PE_COUNT; pe_req_ready in PE_COUNT; pe_req_data out PE_COUNT x REQ_DATAW.
REQ-009 SHALL have ports: pe_rsp_valid in PE_COUNT; pe_rsp_ready out PE_COUNT; pe_rsp_data in PE_COUNT x RSP_DATAW.
REQ-010 SHALL have ports: rsp_valid out 1; rsp_ready in 1; rsp_data out RSP_DATAW; rsp_pe out UP(CLOG2(PE_COUNT)) source PE.
REQ-011 SHALL have ports: flush in 1 drain request; busy out 1 high in DRAIN; pending out PE_COUNT x CNTW per-PE counts (CNTW = CLOG2(MAX_PENDING+1)); err_underflow out 1 sticky.

Function
REQ-012 Target SHALL be req_sel when SEL_MODE=0; when SEL_MODE=1, the PE with lowest pending count, ties to lowest index, req_sel ignored.
REQ-013 req_ready SHALL be high only in RUN, with target buffer empty or draining this cycle, and pending[target] < MAX_PENDING.
REQ-014 req_sel >= PE_COUNT (SEL_MODE=0) SHALL force req_ready low.
REQ-015 Each PE SHALL own a 1-entry request register; an accepted request appears on pe_req_valid/pe_req_data of the target exactly 1 cycle later.
REQ-016 pe_req_valid/pe_req_data SHALL hold stable until pe_req_ready; back-to-back acceptance to the same PE SHALL occur at full rate when pe_req_ready stays high.
REQ-017 pending[i] SHALL increment on request acceptance to PE i and decrement on pe_rsp_valid[i] && pe_rsp_ready[i]; simultaneous both SHALL leave it unchanged.
REQ-018 A response handshake while pending[i]=0 (without same-cycle increment) SHALL keep pending[i]=0 and set err_underflow until reset.
REQ-019 Responses SHALL be arbitrated round-robin; the pointer SHALL advance to one past the granted PE after each grant.
REQ-020 pe_rsp_ready[i] SHALL be high only for the granted PE and only when the response output register is empty or rsp_ready is high.
REQ-021 Granted response SHALL appear on rsp_valid/rsp_data/rsp_pe 1 cycle after the PE handshake and hold until rsp_ready.
REQ-022 FSM states RUN, DRAIN: RUN->DRAIN when flush sampled high; DRAIN->RUN when all pending are 0 and all request registers empty; flush held in DRAIN has no further effect.
REQ-023 In DRAIN, req_ready SHALL be low; in-flight requests and responses SHALL continue to drain; busy = (state==DRAIN).
REQ-024 If the DRAIN exit condition already holds when flush is sampled, DRAIN SHALL last exactly 1 cycle.

Reset
REQ-025 On clk edge with reset_n low: state=RUN, all request/response registers empty, pe_req_valid=0, rsp_valid=0, pending=0, round-robin pointer=0, err_underflow=0.
REQ-026 req_ready and pe_rsp_ready SHALL be low while reset_n is low; reset mid-transfer SHALL discard all buffered data.

Structure
REQ-027 FSM state enum SHALL reside in VX_gpu_pkg; CNTW derived locally.
REQ-028 Response path SHALL use sub-module VX_stream_arb (round-robin, OUT_BUF=1); request registers SHALL be per-PE inline logic.

Verification
REQ-029 SEL_MODE=0, req_sel=1, data=0xA5 accepted at cycle 0 -> pe_req_valid[1]=1, data 0xA5 at cycle 1; pending[1]=1.
REQ-030 MAX_PENDING=4, PE0 never responds, 5 requests to PE0 -> 4 accepted, 5th stalls with req_ready=0 until one PE0 response handshake.
REQ-031 SEL_MODE=1, pending={PE0:2, PE1:1} -> next request goes to PE1; with pending equal 1/1 -> PE0.
REQ-032 Both PEs hold pe_rsp_valid continuously, rsp_ready=1, pointer 0 -> rsp_pe sequence 0,1,0,1.
REQ-033 flush with 3 pending on PE0 -> busy=1, req_ready=0 until third response handshake, RUN the following cycle.
REQ-034 pe_rsp handshake on PE1 with pending[1]=0 -> err_underflow=1, pending[1] stays 0; cleared only by reset_n low.

Source files
------------

// File: rtl/vx_pe_dispatch_pkg.sv
// Shared types and helpers for the PE dispatch block: the RUN/DRAIN state
// encoding and a width helper for select and index fields.
package vx_pe_dispatch_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } dispatch_state_e;

    // Always returns at least 1, so a single-PE build still gets a 1-bit select.
    function automatic int up_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_pe_dispatch_if.sv
// Bundle of host-side and PE-side handshakes around the dispatcher.
// The dispatcher uses the slave modport; the environment uses the master modport.
interface vx_pe_dispatch_if #(
    parameter int PE_COUNT    = 2,
    parameter int REQ_DATAW   = 64,
    parameter int RSP_DATAW   = 64,
    parameter int MAX_PENDING = 4
);
    localparam int SELW = vx_pe_dispatch_pkg::up_clog2(PE_COUNT);
    localparam int CNTW = $clog2(MAX_PENDING + 1);

    logic                                req_valid;
    logic                                req_ready;
    logic [REQ_DATAW-1:0]                req_data;
    logic [SELW-1:0]                     req_sel;

    logic [PE_COUNT-1:0]                 pe_req_valid;
    logic [PE_COUNT-1:0]                 pe_req_ready;
    logic [PE_COUNT-1:0][REQ_DATAW-1:0]  pe_req_data;

    logic [PE_COUNT-1:0]                 pe_rsp_valid;
    logic [PE_COUNT-1:0]                 pe_rsp_ready;
    logic [PE_COUNT-1:0][RSP_DATAW-1:0]  pe_rsp_data;

    logic                                rsp_valid;
    logic                                rsp_ready;
    logic [RSP_DATAW-1:0]                rsp_data;
    logic [SELW-1:0]                     rsp_pe;

    logic                                flush;
    logic                                busy;
    logic [PE_COUNT-1:0][CNTW-1:0]       pending;
    logic                                err_underflow;

    modport slave (
        input  req_valid, req_data, req_sel, pe_req_ready, pe_rsp_valid, pe_rsp_data,
               rsp_ready, flush,
        output req_ready, pe_req_valid, pe_req_data, pe_rsp_ready, rsp_valid, rsp_data,
               rsp_pe, busy, pending, err_underflow
    );

    modport master (
        output req_valid, req_data, req_sel, pe_req_ready, pe_rsp_valid, pe_rsp_data,
               rsp_ready, flush,
        input  req_ready, pe_req_valid, pe_req_data, pe_rsp_ready, rsp_valid, rsp_data,
               rsp_pe, busy, pending, err_underflow
    );

endinterface

// File: rtl/vx_pe_dispatch_stream_arb.sv
// Round-robin stream arbiter: merges N valid/ready streams into one, tagging each
// beat with its source index, with an optional registered output stage.
module vx_pe_dispatch_stream_arb
    import vx_pe_dispatch_pkg::*;
#(
    parameter int NUM_INPUTS = 2,
    parameter int DATAW      = 64,
    parameter int OUT_BUF    = 1,
    localparam int SELW      = up_clog2(NUM_INPUTS)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_INPUTS-1:0]             valid_in,
    output logic [NUM_INPUTS-1:0]             ready_in,
    input  logic [NUM_INPUTS-1:0][DATAW-1:0]  data_in,
    output logic                              valid_out,
    input  logic                              ready_out,
    output logic [DATAW-1:0]                  data_out,
    output logic [SELW-1:0]                   sel_out
);

    logic [SELW-1:0] rr_ptr;
    logic [SELW-1:0] grant;
    logic            grant_valid;
    logic            load_ok;
    logic            fire;

    // Search starts at the pointer and wraps, so the first valid input found wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (!grant_valid && valid_in[(int'(rr_ptr) + k) % NUM_INPUTS]) begin
                grant_valid = 1'b1;
                grant       = SELW'((int'(rr_ptr) + k) % NUM_INPUTS);
            end
        end
    end

    assign fire = reset_n && grant_valid && load_ok;

    always_comb begin
        ready_in = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            ready_in[i] = fire && (int'(grant) == i);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (fire) begin
            rr_ptr <= SELW'((int'(grant) + 1) % NUM_INPUTS);
        end
    end

    if (OUT_BUF != 0) begin : g_out_reg
        logic             out_valid;
        logic [DATAW-1:0] out_data;
        logic [SELW-1:0]  out_sel;

        assign load_ok = !out_valid || ready_out;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                out_valid <= 1'b0;
                out_data  <= '0;
                out_sel   <= '0;
            end else if (fire) begin
                out_valid <= 1'b1;
                out_data  <= data_in[grant];
                out_sel   <= grant;
            end else if (ready_out) begin
                out_valid <= 1'b0;
            end
        end

        assign valid_out = out_valid;
        assign data_out  = out_data;
        assign sel_out   = out_sel;
    end else begin : g_out_comb
        assign load_ok   = ready_out;
        assign valid_out = reset_n && grant_valid;
        assign data_out  = data_in[grant];
        assign sel_out   = grant;
    end

endmodule

// File: rtl/vx_pe_dispatch.sv
// Request dispatcher for a set of processing elements: routes host requests to
// per-PE one-entry buffers, tracks outstanding work and merges PE responses.
module vx_pe_dispatch
    import vx_pe_dispatch_pkg::*;
#(
    parameter int PE_COUNT    = 2,
    parameter int REQ_DATAW   = 64,
    parameter int RSP_DATAW   = 64,
    parameter int MAX_PENDING = 4,
    parameter int SEL_MODE    = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    vx_pe_dispatch_if.slave        bus
);

    localparam int SELW = up_clog2(PE_COUNT);
    localparam int CNTW = $clog2(MAX_PENDING + 1);
    localparam logic [CNTW-1:0] MAX_CNT = CNTW'(MAX_PENDING);

    dispatch_state_e                    state;
    dispatch_state_e                    state_next;
    logic [PE_COUNT-1:0]                rq_valid;
    logic [PE_COUNT-1:0][REQ_DATAW-1:0] rq_data;
    logic [PE_COUNT-1:0][CNTW-1:0]      pending;
    logic                               err_underflow;
    logic [SELW-1:0]                    target;
    logic [CNTW-1:0]                    best_cnt;
    logic                               target_ok;
    logic                               req_ready_c;
    logic                               accept;
    logic                               all_idle;
    logic [PE_COUNT-1:0]                inc_vec;
    logic [PE_COUNT-1:0]                arb_ready;
    logic [PE_COUNT-1:0]                rsp_fire;

    // Least-loaded mode keeps the earliest minimum, so ties go to the lowest index.
    always_comb begin
        target    = '0;
        target_ok = 1'b0;
        best_cnt  = pending[0];
        if (SEL_MODE == 0) begin
            target    = bus.req_sel;
            target_ok = (int'(bus.req_sel) < PE_COUNT);
        end else begin
            target_ok = 1'b1;
            for (int i = 1; i < PE_COUNT; i++) begin
                if (pending[i] < best_cnt) begin
                    target   = SELW'(i);
                    best_cnt = pending[i];
                end
            end
        end
    end

    always_comb begin
        req_ready_c = 1'b0;
        if (reset_n && (state == ST_RUN) && target_ok) begin
            req_ready_c = (!rq_valid[target] || bus.pe_req_ready[target])
                          && (pending[target] < MAX_CNT);
        end
    end

    assign accept = bus.req_valid && req_ready_c;

    always_comb begin
        inc_vec = '0;
        for (int i = 0; i < PE_COUNT; i++) begin
            inc_vec[i] = accept && (int'(target) == i);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rq_valid <= '0;
            rq_data  <= '0;
        end else begin
            for (int i = 0; i < PE_COUNT; i++) begin
                if (inc_vec[i]) begin
                    rq_valid[i] <= 1'b1;
                    rq_data[i]  <= bus.req_data;
                end else if (bus.pe_req_ready[i]) begin
                    rq_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign rsp_fire = bus.pe_rsp_valid & arb_ready;

    // A response with nothing outstanding saturates at zero and latches the error.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending       <= '0;
            err_underflow <= 1'b0;
        end else begin
            for (int i = 0; i < PE_COUNT; i++) begin
                if (inc_vec[i] && !rsp_fire[i]) begin
                    pending[i] <= pending[i] + 1'b1;
                end else if (rsp_fire[i] && !inc_vec[i]) begin
                    if (pending[i] == '0) begin
                        err_underflow <= 1'b1;
                    end else begin
                        pending[i] <= pending[i] - 1'b1;
                    end
                end
            end
        end
    end

    assign all_idle = (rq_valid == '0) && (pending == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:   if (bus.flush) state_next = ST_DRAIN;
            ST_DRAIN: if (all_idle)  state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    vx_pe_dispatch_stream_arb #(
        .NUM_INPUTS (PE_COUNT),
        .DATAW      (RSP_DATAW),
        .OUT_BUF    (1)
    ) rsp_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid_in  (bus.pe_rsp_valid),
        .ready_in  (arb_ready),
        .data_in   (bus.pe_rsp_data),
        .valid_out (bus.rsp_valid),
        .ready_out (bus.rsp_ready),
        .data_out  (bus.rsp_data),
        .sel_out   (bus.rsp_pe)
    );

    assign bus.req_ready     = req_ready_c;
    assign bus.pe_req_valid  = rq_valid;
    assign bus.pe_req_data   = rq_data;
    assign bus.pe_rsp_ready  = arb_ready;
    assign bus.busy          = (state == ST_DRAIN);
    assign bus.pending       = pending;
    assign bus.err_underflow = err_underflow;

endmodule

// File: tb/tb_vx_pe_dispatch.sv
// Directed testbench for vx_pe_dispatch: explicit-select instance for most scenarios,
// a least-loaded instance for auto-select.
module tb_vx_pe_dispatch;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vx_pe_dispatch_if #(.PE_COUNT(2), .REQ_DATAW(64), .RSP_DATAW(64), .MAX_PENDING(4)) bus0 ();
    vx_pe_dispatch_if #(.PE_COUNT(2), .REQ_DATAW(64), .RSP_DATAW(64), .MAX_PENDING(4)) bus1 ();

    vx_pe_dispatch #(.PE_COUNT(2), .REQ_DATAW(64), .RSP_DATAW(64), .MAX_PENDING(4), .SEL_MODE(0))
        dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));

    vx_pe_dispatch #(.PE_COUNT(2), .REQ_DATAW(64), .RSP_DATAW(64), .MAX_PENDING(4), .SEL_MODE(1))
        dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

    task automatic clear_inputs();
        bus0.req_valid = 0; bus0.req_data = '0; bus0.req_sel = '0; bus0.pe_req_ready = '0;
        bus0.pe_rsp_valid = '0; bus0.pe_rsp_data = '0; bus0.rsp_ready = 0; bus0.flush = 0;
        bus1.req_valid = 0; bus1.req_data = '0; bus1.req_sel = '0; bus1.pe_req_ready = '0;
        bus1.pe_rsp_valid = '0; bus1.pe_rsp_data = '0; bus1.rsp_ready = 0; bus1.flush = 0;
    endtask

    task automatic reset_all();
        @(negedge clk);
        reset_n = 0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 0;
        bus0.req_valid = 1; bus0.pe_rsp_valid = 2'b11;
        #1;
        checks++; if (bus0.req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 0", bus0.req_ready); end
        checks++; if (bus0.pe_rsp_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_pe_rsp_ready: got %b expected 00", bus0.pe_rsp_ready); end
        @(negedge clk);
        #1;
        checks++; if (bus0.pe_req_valid !== 2'b00) begin errors++; $display("[TB] FAIL reset_pe_req_valid: got %b expected 00", bus0.pe_req_valid); end
        checks++; if (bus0.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", bus0.rsp_valid); end
        checks++; if (bus0.pending !== '0) begin errors++; $display("[TB] FAIL reset_pending: got %h expected 0", bus0.pending); end
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus0.busy); end
        checks++; if (bus0.err_underflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus0.err_underflow); end
        clear_inputs();
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_single();
        bus0.req_valid = 1; bus0.req_sel = 1'b1; bus0.req_data = 64'hA5;
        #1;
        checks++; if (bus0.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready: got %b expected 1", bus0.req_ready); end
        @(negedge clk);
        bus0.req_valid = 0;
        #1;
        checks++; if (bus0.pe_req_valid !== 2'b10) begin errors++; $display("[TB] FAIL single_pe_valid: got %b expected 10", bus0.pe_req_valid); end
        checks++; if (bus0.pe_req_data[1] !== 64'hA5) begin errors++; $display("[TB] FAIL single_pe_data: got %h expected a5", bus0.pe_req_data[1]); end
        checks++; if (bus0.pending[1] !== 3'd1) begin errors++; $display("[TB] FAIL single_pending: got %0d expected 1", bus0.pending[1]); end
        @(negedge clk);
        #1;
        checks++; if (bus0.pe_req_valid !== 2'b10 || bus0.pe_req_data[1] !== 64'hA5) begin errors++; $display("[TB] FAIL single_hold: got %b/%h expected 10/a5", bus0.pe_req_valid, bus0.pe_req_data[1]); end
        bus0.pe_req_ready = 2'b11;
        @(negedge clk);
        bus0.pe_req_ready = 2'b00;
        #1;
        checks++; if (bus0.pe_req_valid !== 2'b00) begin errors++; $display("[TB] FAIL single_drained: got %b expected 00", bus0.pe_req_valid); end
        bus0.pe_rsp_valid = 2'b10; bus0.pe_rsp_data[1] = 64'h1234;
        #1;
        checks++; if (bus0.pe_rsp_ready !== 2'b10) begin errors++; $display("[TB] FAIL single_rsp_grant: got %b expected 10", bus0.pe_rsp_ready); end
        @(negedge clk);
        bus0.pe_rsp_valid = 2'b00;
        #1;
        checks++; if (bus0.rsp_valid !== 1'b1 || bus0.rsp_data !== 64'h1234 || bus0.rsp_pe !== 1'b1) begin errors++; $display("[TB] FAIL single_rsp_out: got %b/%h/%b expected 1/1234/1", bus0.rsp_valid, bus0.rsp_data, bus0.rsp_pe); end
        checks++; if (bus0.pending[1] !== 3'd0) begin errors++; $display("[TB] FAIL single_pending_dec: got %0d expected 0", bus0.pending[1]); end
        @(negedge clk);
        bus0.pe_rsp_valid = 2'b01;
        #1;
        checks++; if (bus0.rsp_valid !== 1'b1 || bus0.rsp_data !== 64'h1234) begin errors++; $display("[TB] FAIL single_rsp_hold: got %b/%h expected 1/1234", bus0.rsp_valid, bus0.rsp_data); end
        checks++; if (bus0.pe_rsp_ready !== 2'b00) begin errors++; $display("[TB] FAIL single_rsp_blocked: got %b expected 00", bus0.pe_rsp_ready); end
        bus0.pe_rsp_valid = 2'b00;
        bus0.rsp_ready = 1;
        @(negedge clk);
        #1;
        checks++; if (bus0.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_rsp_taken: got %b expected 0", bus0.rsp_valid); end
    endtask

    task automatic test_max_pending();
        bus0.pe_req_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            bus0.req_valid = 1; bus0.req_sel = 1'b0; bus0.req_data = 64'h10 + 64'(k);
            #1;
            checks++; if (bus0.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL maxp_accept%0d: got %b expected 1", k, bus0.req_ready); end
            @(negedge clk);
            #1;
            checks++; if (bus0.pe_req_valid[0] !== 1'b1 || bus0.pe_req_data[0] !== 64'h10 + 64'(k)) begin errors++; $display("[TB] FAIL maxp_b2b%0d: got %b/%h expected 1/%h", k, bus0.pe_req_valid[0], bus0.pe_req_data[0], 64'h10 + 64'(k)); end
        end
        bus0.req_data = 64'h14;
        #1;
        checks++; if (bus0.req_ready !== 1'b0) begin errors++; $display("[TB] FAIL maxp_stall: got %b expected 0", bus0.req_ready); end
        checks++; if (bus0.pending[0] !== 3'd4) begin errors++; $display("[TB] FAIL maxp_count: got %0d expected 4", bus0.pending[0]); end
        @(negedge clk);
        #1;
        checks++; if (bus0.req_ready !== 1'b0 || bus0.pe_req_valid[0] !== 1'b0) begin errors++; $display("[TB] FAIL maxp_stall2: got %b/%b expected 0/0", bus0.req_ready, bus0.pe_req_valid[0]); end
        bus0.pe_rsp_valid = 2'b01; bus0.pe_rsp_data[0] = 64'h50;
        #1;
        checks++; if (bus0.req_ready !== 1'b0) begin errors++; $display("[TB] FAIL maxp_stall3: got %b expected 0", bus0.req_ready); end
        @(negedge clk);
        bus0.pe_rsp_valid = 2'b00;
        #1;
        checks++; if (bus0.pending[0] !== 3'd3 || bus0.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL maxp_release: got %0d/%b expected 3/1", bus0.pending[0], bus0.req_ready); end
        checks++; if (bus0.rsp_valid !== 1'b1 || bus0.rsp_pe !== 1'b0 || bus0.rsp_data !== 64'h50) begin errors++; $display("[TB] FAIL maxp_rsp: got %b/%b/%h expected 1/0/50", bus0.rsp_valid, bus0.rsp_pe, bus0.rsp_data); end
        @(negedge clk);
        bus0.req_valid = 0;
        #1;
        checks++; if (bus0.pending[0] !== 3'd4 || bus0.pe_req_data[0] !== 64'h14) begin errors++; $display("[TB] FAIL maxp_fifth: got %0d/%h expected 4/14", bus0.pending[0], bus0.pe_req_data[0]); end
        bus0.pe_rsp_valid = 2'b01;
        repeat (4) @(negedge clk);
        bus0.pe_rsp_valid = 2'b00;
        #1;
        checks++; if (bus0.pending[0] !== 3'd0 || bus0.err_underflow !== 1'b0) begin errors++; $display("[TB] FAIL maxp_cleanup: got %0d/%b expected 0/0", bus0.pending[0], bus0.err_underflow); end
    endtask

    task automatic test_round_robin();
        logic [0:0] sel_seq [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        reset_all();
        bus0.pe_req_ready = 2'b11; bus0.rsp_ready = 1;
        for (int k = 0; k < 4; k++) begin
            bus0.req_valid = 1; bus0.req_sel = sel_seq[k]; bus0.req_data = 64'(k);
            @(negedge clk);
        end
        bus0.req_valid = 0;
        bus0.pe_rsp_valid = 2'b11; bus0.pe_rsp_data[0] = 64'h100; bus0.pe_rsp_data[1] = 64'h101;
        #1;
        checks++; if (bus0.pe_rsp_ready !== 2'b01) begin errors++; $display("[TB] FAIL rr_first_grant: got %b expected 01", bus0.pe_rsp_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) bus0.pe_rsp_valid = 2'b00;
            #1;
            checks++; if (bus0.rsp_pe !== 1'(i % 2) || bus0.rsp_data !== 64'h100 + 64'(i % 2)) begin errors++; $display("[TB] FAIL rr_seq%0d: got pe %b data %h expected pe %0d", i, bus0.rsp_pe, bus0.rsp_data, i % 2); end
        end
        checks++; if (bus0.pending !== '0 || bus0.err_underflow !== 1'b0) begin errors++; $display("[TB] FAIL rr_pending: got %h/%b expected 0/0", bus0.pending, bus0.err_underflow); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            bus0.req_valid = 1; bus0.req_sel = 1'b0; bus0.req_data = 64'h20 + 64'(k);
            @(negedge clk);
        end
        bus0.req_valid = 0; bus0.flush = 1;
        #1;
        checks++; if (bus0.busy !== 1'b0 || bus0.pending[0] !== 3'd3) begin errors++; $display("[TB] FAIL flush_pre: got %b/%0d expected 0/3", bus0.busy, bus0.pending[0]); end
        @(negedge clk);
        bus0.req_valid = 1;
        #1;
        checks++; if (bus0.busy !== 1'b1 || bus0.req_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_enter: got %b/%b expected 1/0", bus0.busy, bus0.req_ready); end
        bus0.pe_rsp_valid = 2'b01; bus0.pe_rsp_data[0] = 64'h200;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) begin bus0.pe_rsp_valid = 2'b00; bus0.flush = 0; end
            #1;
            checks++; if (bus0.busy !== 1'b1 || bus0.req_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_drain%0d: got %b/%b expected 1/0", i, bus0.busy, bus0.req_ready); end
        end
        checks++; if (bus0.pending[0] !== 3'd0) begin errors++; $display("[TB] FAIL flush_pending: got %0d expected 0", bus0.pending[0]); end
        @(negedge clk);
        #1;
        checks++; if (bus0.busy !== 1'b0 || bus0.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_exit: got %b/%b expected 0/1", bus0.busy, bus0.req_ready); end
        bus0.req_valid = 0;
    endtask

    task automatic test_flush_idle();
        @(negedge clk);
        bus0.flush = 1;
        @(negedge clk);
        bus0.flush = 0;
        #1;
        checks++; if (bus0.busy !== 1'b1) begin errors++; $display("[TB] FAIL idle_flush_enter: got %b expected 1", bus0.busy); end
        @(negedge clk);
        #1;
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_flush_exit: got %b expected 0", bus0.busy); end
    endtask

    task automatic test_least_loaded();
        bus1.pe_req_ready = 2'b11; bus1.req_sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus1.req_valid = 1; bus1.req_data = 64'h30 + 64'(i);
            @(negedge clk);
            #1;
            checks++; if (bus1.pe_req_valid !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("[TB] FAIL auto_sel%0d: got %b expected %b", i, bus1.pe_req_valid, (i % 2 == 0) ? 2'b01 : 2'b10); end
        end
        bus1.req_valid = 0;
        checks++; if (bus1.pending[0] !== 3'd2 || bus1.pending[1] !== 3'd2) begin errors++; $display("[TB] FAIL auto_pending: got %0d/%0d expected 2/2", bus1.pending[0], bus1.pending[1]); end
    endtask

    task automatic test_underflow();
        @(negedge clk);
        bus0.rsp_ready = 1; bus0.pe_rsp_valid = 2'b10; bus0.pe_rsp_data[1] = 64'h300;
        #1;
        checks++; if (bus0.pe_rsp_ready !== 2'b10) begin errors++; $display("[TB] FAIL uf_grant: got %b expected 10", bus0.pe_rsp_ready); end
        @(negedge clk);
        bus0.pe_rsp_valid = 2'b00; bus0.rsp_ready = 0; bus0.pe_req_ready = 2'b00;
        bus0.req_valid = 1; bus0.req_sel = 1'b0; bus0.req_data = 64'h77;
        #1;
        checks++; if (bus0.err_underflow !== 1'b1 || bus0.pending[1] !== 3'd0) begin errors++; $display("[TB] FAIL uf_flag: got %b/%0d expected 1/0", bus0.err_underflow, bus0.pending[1]); end
        @(negedge clk);
        bus0.req_valid = 0;
        #1;
        checks++; if (bus0.err_underflow !== 1'b1 || bus0.pe_req_valid !== 2'b01 || bus0.rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL uf_sticky: got %b/%b/%b expected 1/01/1", bus0.err_underflow, bus0.pe_req_valid, bus0.rsp_valid); end
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        #1;
        checks++; if (bus0.err_underflow !== 1'b0 || bus0.pe_req_valid !== 2'b00 || bus0.rsp_valid !== 1'b0 || bus0.pending !== '0) begin errors++; $display("[TB] FAIL uf_reset: got %b/%b/%b/%h expected 0/00/0/0", bus0.err_underflow, bus0.pe_req_valid, bus0.rsp_valid, bus0.pending); end
    endtask

    initial begin
        clear_inputs();
        $display("[TB] starting vx_pe_dispatch directed tests");
        test_reset();
        test_single();
        test_max_pending();
        test_round_robin();
        test_flush();
        test_flush_idle();
        test_least_loaded();
        test_underflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
